// File: rtl/p2s_lanes_pkg.sv
// Shared definitions for the p2s_lanes transmitter and its matching s2p receiver:
// ordered-set state encoding and the default 8-bit control symbols.
package p2s_lanes_pkg;

    typedef enum logic [1:0] {
        ST_COM,
        ST_SKP,
        ST_DATA
    } p2s_state_t;

    localparam logic [7:0] COM_DEF = 8'hBC;
    localparam logic [7:0] SKP_DEF = 8'h1C;
    localparam logic [7:0] IDL_DEF = 8'h7C;

endpackage

// File: rtl/p2s_lane_shift.sv
// One serial lane: WIDTH-bit register that loads a symbol or shifts left,
// presenting its MSB as the serial bit.
module p2s_lane_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             load,
    input  logic [WIDTH-1:0] sym,
    output logic             sout
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (enb) begin
            if (load) begin
                shreg <= sym;
            end else begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign sout = shreg[WIDTH-1];

endmodule

// File: rtl/p2s_lanes.sv
// Multi-lane parallel-to-serial transmitter: MSB-first per lane, IDL fill when
// no data is offered, and a COM + SKP ordered set every SKP_INTERVAL symbols.
module p2s_lanes
    import p2s_lanes_pkg::*;
#(
    parameter int unsigned      LANES        = 2,
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      SKP_INTERVAL = 4,
    parameter int unsigned      SKP_LEN      = 3,
    parameter logic [WIDTH-1:0] COM_SYM      = WIDTH'(COM_DEF),
    parameter logic [WIDTH-1:0] SKP_SYM      = WIDTH'(SKP_DEF),
    parameter logic [WIDTH-1:0] IDL_SYM      = WIDTH'(IDL_DEF)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   ENB,
    input  logic [LANES*WIDTH-1:0] IN_DATA,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [LANES-1:0]       SOUT,
    output logic                   SYNC,
    output logic                   K_FLAG
);

    localparam int unsigned    BW       = $clog2(WIDTH);
    localparam int unsigned    KW       = $clog2(SKP_LEN + 1);
    localparam int unsigned    SW       = $clog2(SKP_INTERVAL + 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
    localparam logic [KW-1:0]  SKP_LAST = KW'(SKP_LEN - 1);
    localparam logic [SW-1:0]  SYM_LAST = SW'(SKP_INTERVAL - 1);

    p2s_state_t               state, state_next;
    logic [BW-1:0]            bit_cnt;
    logic [KW-1:0]            skp_cnt, skp_next;
    logic [SW-1:0]            sym_cnt, sym_next;
    logic [LANES*WIDTH-1:0]   load_word;
    logic                     k_next;
    logic                     load;
    logic                     sync_q;
    logic                     k_q;

    // The FSM only advances on the enabled edge that starts a new symbol.
    assign load     = ENB && (bit_cnt == BIT_LAST);
    assign IN_READY = load && (state == ST_DATA) && !reset;

    always_comb begin
        state_next = state;
        skp_next   = skp_cnt;
        sym_next   = sym_cnt;
        load_word  = {LANES{IDL_SYM}};
        k_next     = 1'b1;
        case (state)
            ST_COM: begin
                load_word  = {LANES{COM_SYM}};
                skp_next   = '0;
                state_next = ST_SKP;
            end
            ST_SKP: begin
                load_word = {LANES{SKP_SYM}};
                skp_next  = skp_cnt + KW'(1);
                if (skp_cnt == SKP_LAST) begin
                    state_next = ST_DATA;
                    sym_next   = '0;
                end
            end
            ST_DATA: begin
                if (IN_VALID) begin
                    load_word = IN_DATA;
                    k_next    = 1'b0;
                end
                sym_next = sym_cnt + SW'(1);
                if (sym_cnt == SYM_LAST) begin
                    state_next = ST_COM;
                end
            end
            default: state_next = ST_COM;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= ST_COM;
            bit_cnt <= BIT_LAST;
            skp_cnt <= '0;
            sym_cnt <= '0;
            sync_q  <= 1'b0;
            k_q     <= 1'b0;
        end else if (ENB) begin
            if (load) begin
                bit_cnt <= '0;
                state   <= state_next;
                skp_cnt <= skp_next;
                sym_cnt <= sym_next;
                sync_q  <= 1'b1;
                k_q     <= k_next;
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
                sync_q  <= 1'b0;
            end
        end
    end

    assign SYNC   = sync_q;
    assign K_FLAG = k_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        p2s_lane_shift #(
            .WIDTH(WIDTH)
        ) u_shift (
            .clk   (CLK),
            .reset (reset),
            .enb   (ENB),
            .load  (load),
            .sym   (load_word[l*WIDTH +: WIDTH]),
            .sout  (SOUT[l])
        );
    end

endmodule
